// File: rtl/frame_loader.sv
// frame_loader: raster pixel stream -> three-pixel-wide row memory words.
// Each written word at address a packs {p[a+2], p[a+1], p[a]}, so the blur
// body can fetch a horizontal triple with a single read. The last two
// addresses run past the end of the frame and are padded with zeros.
module frame_loader #(
  parameter int imW     = 16,
  parameter int imH     = 16,
  parameter int addr_w  = 8,
  parameter int idata_w = 24
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               ST,
  input  logic [7:0]         PX_DATA,
  input  logic               PX_VALID,
  output logic               PX_READY,
  output logic [addr_w-1:0]  WADDR,
  output logic [idata_w-1:0] WDATA,
  output logic               WE,
  output logic               BUSY,
  output logic               DONE
);

  localparam int N = imW * imH;
  // Pixel counter is one bit wider than the address so that N itself fits.
  localparam logic [addr_w:0]   N_LAST = (addr_w+1)'(N - 1);
  localparam logic [addr_w-1:0] A_NM2  = addr_w'(N - 2);
  localparam logic [addr_w-1:0] A_NM1  = addr_w'(N - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_FLUSH1,
    S_FLUSH2,
    S_FIN
  } state_t;

  state_t               r_state;
  logic [addr_w:0]      r_n;
  logic [7:0]           r_w0;
  logic [7:0]           r_w1;
  logic                 r_ready;
  logic                 r_we;
  logic [addr_w-1:0]    r_waddr;
  logic [idata_w-1:0]   r_wdata;
  logic                 r_busy;
  logic                 r_done;

  logic                 w_xfer;
  logic                 w_last;
  logic                 w_has2;

  // A pixel moves only when the loader advertised ready during LOAD.
  assign w_xfer = (r_state == S_LOAD) & PX_VALID & r_ready;
  assign w_last = (r_n == N_LAST);
  // Once two pixels sit in the window, the incoming one completes a word.
  assign w_has2 = (r_n >= (addr_w+1)'(2));

  // Frame sequencing, pixel window and registered write port.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_n     <= '0;
      r_w0    <= '0;
      r_w1    <= '0;
      r_ready <= 1'b0;
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      // Strobes are single-cycle unless a state re-asserts them.
      r_we   <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_ready <= 1'b0;
          r_busy  <= 1'b0;
          if (ST) begin
            r_n     <= '0;
            r_w0    <= '0;
            r_w1    <= '0;
            r_ready <= 1'b1;
            r_busy  <= 1'b1;
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (w_xfer) begin
            r_w0 <= r_w1;
            r_w1 <= PX_DATA;
            r_n  <= r_n + (addr_w+1)'(1);
            if (w_has2) begin
              r_we    <= 1'b1;
              r_waddr <= r_n[addr_w-1:0] - addr_w'(2);
              r_wdata <= {PX_DATA, r_w1, r_w0};
            end
            // Last pixel accepted: stop advertising ready, drain the window.
            if (w_last) begin
              r_ready <= 1'b0;
              r_state <= S_FLUSH1;
            end
          end
        end
        S_FLUSH1: begin
          r_we    <= 1'b1;
          r_waddr <= A_NM2;
          r_wdata <= {8'h00, r_w1, r_w0};
          r_state <= S_FLUSH2;
        end
        S_FLUSH2: begin
          r_we    <= 1'b1;
          r_waddr <= A_NM1;
          r_wdata <= {8'h00, 8'h00, r_w1};
          r_state <= S_FIN;
        end
        S_FIN: begin
          // BUSY stays up through the DONE cycle and drops on the next edge
          // unless a new ST arrives then.
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign PX_READY = r_ready;
  assign WE       = r_we;
  assign WADDR    = r_waddr;
  assign WDATA    = r_wdata;
  assign BUSY     = r_busy;
  assign DONE     = r_done;

endmodule

// File: tb/tb_frame_loader.sv
// Bench for frame_loader: a 4x4 instance for the directed frame cases and a
// 16x16 instance for back-to-back full-size frames. Writes are captured on
// the falling edge and compared against words rebuilt from the pixel bases.
module tb_frame_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        st    [2];
  logic [7:0]  pd    [2];
  logic        pv    [2];
  logic        rdy   [2];
  logic [7:0]  waddr [2];
  logic [23:0] wdata [2];
  logic        we    [2];
  logic        busy  [2];
  logic        done  [2];

  int total = 0;
  int bad   = 0;

  // Captured writes and event timestamps, per instance.
  logic [7:0]  wa [2][0:511];
  logic [23:0] wd [2][0:511];
  int wn [2];
  int done_n [2];
  int last_we [2];
  int done_cyc [2];
  int cyc_n = 0;

  always #5 clk = ~clk;

  frame_loader #(.imW(4), .imH(4)) u_small (
    .CLK(clk), .RST(rst), .ST(st[0]), .PX_DATA(pd[0]), .PX_VALID(pv[0]),
    .PX_READY(rdy[0]), .WADDR(waddr[0]), .WDATA(wdata[0]), .WE(we[0]),
    .BUSY(busy[0]), .DONE(done[0])
  );

  frame_loader u_big (
    .CLK(clk), .RST(rst), .ST(st[1]), .PX_DATA(pd[1]), .PX_VALID(pv[1]),
    .PX_READY(rdy[1]), .WADDR(waddr[1]), .WDATA(wdata[1]), .WE(we[1]),
    .BUSY(busy[1]), .DONE(done[1])
  );

  // Write / done capture.
  always @(negedge clk) begin
    cyc_n++;
    for (int d = 0; d < 2; d++) begin
      if (we[d]) begin
        if (wn[d] < 512) begin
          wa[d][wn[d]] = waddr[d];
          wd[d][wn[d]] = wdata[d];
        end
        wn[d]++;
        last_we[d] = cyc_n;
      end
      if (done[d]) begin
        done_n[d]++;
        done_cyc[d] = cyc_n;
      end
    end
  end

  task automatic chk(input string tag, input longint got, input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d want=%0d", tag, got, exp);
    end
  endtask

  task automatic start(input int d);
    @(posedge clk); #1 st[d] = 1'b1;
    @(posedge clk); #1 st[d] = 1'b0;
  endtask

  // Offer pixels base, base+1, ... until np transfers have happened.
  // gap>0 holds PX_VALID high only on every gap-th cycle; st_at raises ST
  // while pixel st_at is being offered.
  task automatic feed(input int d, input int base, input int gap,
                      input int st_at, input int np);
    int i = 0;
    int cyc = 0;
    logic x;
    pd[d] = 8'(base);
    pv[d] = 1'b1;
    while (i < np && cyc < 3000) begin
      @(negedge clk);
      x = rdy[d] & pv[d];
      @(posedge clk); #1;
      cyc++;
      if (x) begin
        i++;
        pd[d] = 8'(base + i);
      end
      pv[d] = (gap == 0) || (cyc % gap == 0);
      st[d] = (i == st_at);
    end
    pv[d] = 1'b0;
    st[d] = 1'b0;
    chk("feed_count", i, np);
  endtask

  // Wait for DONE, check its timing, optionally chain the next ST.
  task automatic wait_done(input int d, input bit chain);
    bit seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      seen = done[d];
    end
    chk("done_seen", seen, 1);
    #1 chk("done_after_last_we", done_cyc[d] - last_we[d], 1);
    if (chain) st[d] = 1'b1;
    @(posedge clk); #1 st[d] = 1'b0;
    @(negedge clk);
    chk("done_one_cycle", done[d], 0);
    chk(chain ? "busy_restart" : "busy_after_done", busy[d], chain ? 1 : 0);
    @(posedge clk); #1;
  endtask

  task automatic check_frame(input int d, input int base, input int off, input int cnt);
    int n;
    logic [7:0] p0, p1, p2;
    n = (d == 0) ? 16 : 256;
    chk("write_count", cnt, n);
    for (int a = 0; a < n; a++) begin
      p0 = 8'(base + a);
      p1 = 8'(base + a + 1);
      p2 = 8'(base + a + 2);
      if (a >= n - 2) p2 = 8'h00;
      if (a == n - 1) p1 = 8'h00;
      chk("waddr", wa[d][off + a], a);
      chk("wdata", wd[d][off + a], {p2, p1, p0});
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ready"}, rdy[0], 0);
    chk({tag, "_we"}, we[0], 0);
    chk({tag, "_waddr"}, waddr[0], 0);
    chk({tag, "_wdata"}, wdata[0], 0);
    chk({tag, "_busy"}, busy[0], 0);
    chk({tag, "_done"}, done[0], 0);
  endtask

  initial begin
    #4000000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int off, off2, dn;
    for (int d = 0; d < 2; d++) begin
      st[d] = 1'b0; pv[d] = 1'b0; pd[d] = 8'h00;
      wn[d] = 0; done_n[d] = 0; last_we[d] = 0; done_cyc[d] = 0;
    end
    #1 rst = 1'b1;
    #2 chk_zero("reset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Valid pixels in IDLE without ST are ignored.
    pv[0] = 1'b1; pd[0] = 8'd55;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("idle_ready", rdy[0], 0);
      chk("idle_we", we[0], 0);
    end
    @(posedge clk); #1 pv[0] = 1'b0;

    // Plain frame, PX_VALID held high.
    off = wn[0];
    start(0); feed(0, 0, 0, -1, 16); wait_done(0, 1'b0);
    check_frame(0, 0, off, wn[0] - off);

    // Valid only every third cycle.
    off = wn[0];
    start(0); feed(0, 20, 3, -1, 16); wait_done(0, 1'b0);
    check_frame(0, 20, off, wn[0] - off);

    // ST pulsed mid-frame is ignored.
    off = wn[0];
    start(0); feed(0, 40, 0, 5, 16); wait_done(0, 1'b0);
    check_frame(0, 40, off, wn[0] - off);

    // Reset mid-cycle after 7 pixels: outputs clear at once, no DONE.
    dn = done_n[0];
    start(0); feed(0, 60, 0, -1, 7);
    @(posedge clk); #3 rst = 1'b1;
    #1 chk_zero("midrst");
    @(posedge clk); #1 rst = 1'b0;
    pv[0] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("postrst_ready", rdy[0], 0);
      chk("postrst_we", we[0], 0);
    end
    @(posedge clk); #1 pv[0] = 1'b0;
    chk("no_done_after_rst", done_n[0], dn);

    off = wn[0];
    start(0); feed(0, 100, 0, -1, 16); wait_done(0, 1'b0);
    check_frame(0, 100, off, wn[0] - off);

    // Full-size instance: two frames, second ST in the DONE cycle.
    off = wn[1];
    start(1); feed(1, 0, 0, -1, 256); wait_done(1, 1'b1);
    off2 = wn[1];
    feed(1, 7, 0, -1, 256); wait_done(1, 1'b0);
    check_frame(1, 0, off, off2 - off);
    check_frame(1, 7, off2, wn[1] - off2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
